// File: rtl/trace_capture_sched_pkg.sv
// Shared trace encodings: FIFO record command codes and capture FSM state codes.
package trace_capture_sched_pkg;

  typedef logic [1:0] fifo_cmd_t;

  localparam fifo_cmd_t FE_FIFO_CMD_DATA = 2'd1;
  localparam fifo_cmd_t FE_FIFO_CMD_TIME = 2'd2;
  localparam fifo_cmd_t FE_FIFO_CMD_STAT = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // DATA and STAT records carry an event; TIME records only carry elapsed time.
  function automatic logic is_event_cmd(input fifo_cmd_t cmd);
    return cmd != FE_FIFO_CMD_TIME;
  endfunction

endpackage

// File: rtl/trace_sched_timestamp.sv
// Saturating capture timestamp: cleared outside CAPTURE, reloads to 1 whenever a
// record is issued, otherwise counts up and sticks at all-ones.
module trace_sched_timestamp #(
  parameter int pWIDTH = 16
) (
  input  logic              trace_clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load_one,
  output logic [pWIDTH-1:0] o_ts
);

  logic [pWIDTH-1:0] r_ts;

  always_ff @(posedge trace_clk) begin
    if (reset || i_clear) begin
      r_ts <= '0;
    end else if (i_load_one) begin
      r_ts <= pWIDTH'(1);
    end else if (!(&r_ts)) begin
      r_ts <= r_ts + pWIDTH'(1);
    end
  end

  assign o_ts = r_ts;

endmodule

// File: rtl/trace_capture_sched.sv
// Trace capture scheduler: arms/triggers capture, turns front-end events into
// timestamped FIFO records. Optional drop counter under TRACE_SCHED_DROP_COUNT_EN.
module trace_capture_sched
  import trace_capture_sched_pkg::*;
#(
  parameter int pTIMESTAMP_FULL_WIDTH = 16,
  parameter int pCOUNT_WIDTH          = 16
) (
  input  logic                             trace_clk,
  input  logic                             reset,
  input  logic                             I_arm,
  input  logic                             I_abort,
  input  logic                             I_trigger_mode,
  input  logic                             I_trigger,
  input  logic [pCOUNT_WIDTH-1:0]          I_max_events,
  input  logic                             I_event,
  input  logic [1:0]                       I_data_cmd,
  input  logic [15:0]                      I_max_short_timestamp,
  input  logic                             I_fifo_write_allowed,
  output logic                             O_fifo_wr,
  output logic [1:0]                       O_fifo_command,
  output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
  output logic [1:0]                       O_state,
  output logic                             O_overflow,
  output logic [pCOUNT_WIDTH-1:0]          O_drop_count
);

  logic [1:0]                       r_state;
  logic [1:0]                       w_state_next;
  logic [pCOUNT_WIDTH-1:0]          r_count;
  logic [pCOUNT_WIDTH-1:0]          w_count_next;
  logic                             r_pend_valid;
  fifo_cmd_t                        r_pend_cmd;
  logic                             r_fifo_wr;
  fifo_cmd_t                        r_fifo_cmd;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] r_fifo_time;
  logic                             r_overflow;
  logic [pTIMESTAMP_FULL_WIDTH-1:0] w_ts;

  logic      w_in_cap;
  logic      w_short;
  logic      w_want;
  fifo_cmd_t w_want_cmd;
  logic      w_set_pend;
  logic      w_issue;
  logic      w_blocked;
  logic      w_lost_blocked;
  logic      w_lost_collide;
  logic      w_enter_armed;

  assign w_in_cap = (r_state == ST_CAPTURE) && !I_abort;
  assign w_short  = 64'(w_ts) <= 64'(I_max_short_timestamp);

  // Record selection: a pending event record wins, then a new event, then a
  // saturation TIME record so the timeline never silently stalls.
  always_comb begin
    w_want     = 1'b0;
    w_want_cmd = FE_FIFO_CMD_TIME;
    w_set_pend = 1'b0;
    if (w_in_cap) begin
      if (r_pend_valid) begin
        w_want     = 1'b1;
        w_want_cmd = r_pend_cmd;
      end else if (I_event) begin
        w_want     = 1'b1;
        w_want_cmd = w_short ? fifo_cmd_t'(I_data_cmd) : FE_FIFO_CMD_TIME;
        w_set_pend = !w_short;
      end else if (&w_ts) begin
        w_want = 1'b1;
      end
    end
  end

  assign w_issue        = w_want && I_fifo_write_allowed;
  assign w_blocked      = w_want && !I_fifo_write_allowed;
  assign w_lost_blocked = w_blocked && (r_pend_valid || I_event);
  assign w_lost_collide = w_in_cap && r_pend_valid && I_event;

  assign w_count_next = (w_issue && is_event_cmd(w_want_cmd) && !(&r_count))
                        ? r_count + pCOUNT_WIDTH'(1) : r_count;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (I_arm) w_state_next = ST_ARMED;
      ST_ARMED:   if (!I_trigger_mode || I_trigger) w_state_next = ST_CAPTURE;
      ST_CAPTURE: if ((I_max_events != '0) && (w_count_next == I_max_events))
                    w_state_next = ST_DONE;
      ST_DONE:    if (I_arm) w_state_next = ST_ARMED;
      default:    w_state_next = ST_IDLE;
    endcase
    if (I_abort) w_state_next = ST_IDLE;
  end

  assign w_enter_armed = (w_state_next == ST_ARMED) && (r_state != ST_ARMED);

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_cmd   <= FE_FIFO_CMD_DATA;
      r_fifo_wr    <= 1'b0;
      r_fifo_cmd   <= '0;
      r_fifo_time  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_enter_armed ? '0 : w_count_next;
      // A pending record only survives if its TIME record actually went out.
      r_pend_valid <= w_set_pend && w_issue;
      if (w_set_pend) r_pend_cmd <= fifo_cmd_t'(I_data_cmd);
      r_fifo_wr    <= w_issue;
      if (w_issue) begin
        r_fifo_cmd  <= w_want_cmd;
        r_fifo_time <= w_ts;
      end
      if (w_enter_armed) r_overflow <= 1'b0;
      else if (w_blocked || w_lost_collide) r_overflow <= 1'b1;
    end
  end

  trace_sched_timestamp #(
    .pWIDTH (pTIMESTAMP_FULL_WIDTH)
  ) u_timestamp (
    .trace_clk  (trace_clk),
    .reset      (reset),
    .i_clear    (r_state != ST_CAPTURE),
    .i_load_one (w_issue),
    .o_ts       (w_ts)
  );

`ifdef TRACE_SCHED_DROP_COUNT_EN
  logic [pCOUNT_WIDTH-1:0] r_drop_count;
  logic [pCOUNT_WIDTH:0]   w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_count} + (pCOUNT_WIDTH+1)'(w_lost_blocked)
                      + (pCOUNT_WIDTH+1)'(w_lost_collide);

  always_ff @(posedge trace_clk) begin
    if (reset || w_enter_armed) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_sum[pCOUNT_WIDTH] ? '1 : w_drop_sum[pCOUNT_WIDTH-1:0];
    end
  end

  assign O_drop_count = r_drop_count;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_lost_blocked;
  assign O_drop_count  = '0;
`endif

  assign O_fifo_wr      = r_fifo_wr;
  assign O_fifo_command = r_fifo_cmd;
  assign O_fifo_time    = r_fifo_time;
  assign O_state        = r_state;
  assign O_overflow     = r_overflow;

endmodule

// File: tb/tb_trace_capture_sched.sv
// Directed bench for trace_capture_sched; expected values hand-computed per step.
module tb_trace_capture_sched;
  import trace_capture_sched_pkg::*;

`ifdef TRACE_SCHED_DROP_COUNT_EN
  localparam int DROP_EXP = 1;
`else
  localparam int DROP_EXP = 0;
`endif

  logic        trace_clk = 1'b0;
  logic        reset;
  logic        I_arm, I_abort, I_trigger_mode, I_trigger, I_event, I_fifo_write_allowed;
  logic [15:0] I_max_events;
  logic [1:0]  I_data_cmd;
  logic [15:0] I_max_short_timestamp;
  logic        O_fifo_wr, O_overflow;
  logic [1:0]  O_fifo_command, O_state;
  logic [15:0] O_fifo_time, O_drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int spurious;

  always #5 trace_clk = ~trace_clk;

  trace_capture_sched #(
    .pTIMESTAMP_FULL_WIDTH (16),
    .pCOUNT_WIDTH          (16)
  ) dut (
    .trace_clk             (trace_clk),
    .reset                 (reset),
    .I_arm                 (I_arm),
    .I_abort               (I_abort),
    .I_trigger_mode        (I_trigger_mode),
    .I_trigger             (I_trigger),
    .I_max_events          (I_max_events),
    .I_event               (I_event),
    .I_data_cmd            (I_data_cmd),
    .I_max_short_timestamp (I_max_short_timestamp),
    .I_fifo_write_allowed  (I_fifo_write_allowed),
    .O_fifo_wr             (O_fifo_wr),
    .O_fifo_command        (O_fifo_command),
    .O_fifo_time           (O_fifo_time),
    .O_state               (O_state),
    .O_overflow            (O_overflow),
    .O_drop_count          (O_drop_count)
  );

  task automatic tick();
    @(posedge trace_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [1:0] cmd, input logic [15:0] tval);
    check({tag, "_wr"}, 32'(O_fifo_wr), 32'(1));
    check({tag, "_cmd"}, 32'(O_fifo_command), 32'(cmd));
    check({tag, "_time"}, 32'(O_fifo_time), 32'(tval));
    $display("record %s: wr=%0d cmd=%0d time=%0d", tag, O_fifo_wr, O_fifo_command, O_fifo_time);
  endtask

  initial begin
    reset = 1'b1; I_arm = 1'b0; I_abort = 1'b0; I_trigger_mode = 1'b0; I_trigger = 1'b0;
    I_event = 1'b0; I_data_cmd = FE_FIFO_CMD_DATA; I_max_events = 16'd0;
    I_max_short_timestamp = 16'd255; I_fifo_write_allowed = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(O_state), 32'(ST_IDLE));
    check("rst_wr", 32'(O_fifo_wr), 32'(0));
    check("rst_cmd", 32'(O_fifo_command), 32'(0));
    check("rst_time", 32'(O_fifo_time), 32'(0));
    check("rst_ovf", 32'(O_overflow), 32'(0));
    check("rst_drop", 32'(O_drop_count), 32'(0));
    reset = 1'b0;

    // Mode 0: events at CAPTURE cycles 3 and 5 -> times 3 then 2.
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    check("a_armed", 32'(O_state), 32'(ST_ARMED));
    tick();
    check("a_capture", 32'(O_state), 32'(ST_CAPTURE));
    repeat (3) tick();
    I_event = 1'b1; I_data_cmd = FE_FIFO_CMD_DATA; tick(); I_event = 1'b0;
    check_rec("a_ev1", FE_FIFO_CMD_DATA, 16'd3);
    tick();
    check("a_gap_wr", 32'(O_fifo_wr), 32'(0));
    I_event = 1'b1; I_data_cmd = FE_FIFO_CMD_STAT; tick(); I_event = 1'b0;
    check_rec("a_ev2", FE_FIFO_CMD_STAT, 16'd2);
    tick();
    check("a_pulse_wr", 32'(O_fifo_wr), 32'(0));
    check("a_ovf", 32'(O_overflow), 32'(0));

    // Long timestamp: TIME 300 then event record time 1; colliding event dropped.
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    check("b_abort_idle", 32'(O_state), 32'(ST_IDLE));
    I_arm = 1'b1; tick(); I_arm = 1'b0; tick();
    repeat (300) tick();
    I_event = 1'b1; I_data_cmd = FE_FIFO_CMD_DATA; tick();
    check_rec("b_time", FE_FIFO_CMD_TIME, 16'd300);
    tick(); I_event = 1'b0;
    check_rec("b_pend", FE_FIFO_CMD_DATA, 16'd1);
    check("b_collide_ovf", 32'(O_overflow), 32'(1));
    tick();
    check("b_after_wr", 32'(O_fifo_wr), 32'(0));

    // Idle capture: saturation TIME record at 0xFFFF, then ts restarts at 1.
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    check("c_arm_clr_ovf", 32'(O_overflow), 32'(0));
    tick();
    spurious = 0;
    for (int i = 0; i < 65535; i++) begin
      tick();
      if (O_fifo_wr) spurious++;
    end
    check("c_no_early_wr", 32'(spurious), 32'(0));
    tick();
    check_rec("c_sat", FE_FIFO_CMD_TIME, 16'hFFFF);
    I_event = 1'b1; I_data_cmd = FE_FIFO_CMD_DATA; tick(); I_event = 1'b0;
    check_rec("c_reload", FE_FIFO_CMD_DATA, 16'd1);

    // Event limit 2: second write reaches DONE, third event ignored.
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    I_max_events = 16'd2;
    I_arm = 1'b1; tick(); I_arm = 1'b0; tick();
    tick();
    I_event = 1'b1; tick(); I_event = 1'b0;
    check_rec("d_ev1", FE_FIFO_CMD_DATA, 16'd1);
    check("d_still_cap", 32'(O_state), 32'(ST_CAPTURE));
    tick();
    I_event = 1'b1; tick(); I_event = 1'b0;
    check_rec("d_ev2", FE_FIFO_CMD_DATA, 16'd2);
    check("d_done", 32'(O_state), 32'(ST_DONE));
    I_event = 1'b1; tick(); I_event = 1'b0;
    tick();
    check("d_ev3_wr", 32'(O_fifo_wr), 32'(0));
    check("d_ev3_ovf", 32'(O_overflow), 32'(0));

    // FIFO full during one event: no write, overflow, drop, ts not reloaded.
    I_max_events = 16'd0;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    check("e_done_rearm", 32'(O_state), 32'(ST_ARMED));
    tick();
    repeat (2) tick();
    I_fifo_write_allowed = 1'b0; I_event = 1'b1; tick();
    check("e_blocked_wr", 32'(O_fifo_wr), 32'(0));
    check("e_ovf", 32'(O_overflow), 32'(1));
    check("e_drop", 32'(O_drop_count), 32'(DROP_EXP));
    I_fifo_write_allowed = 1'b1; tick(); I_event = 1'b0;
    check_rec("e_no_reload", FE_FIFO_CMD_DATA, 16'd3);

    // Mode 1: trigger-cycle event ignored; abort discards a pending record.
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    I_trigger_mode = 1'b1;
    I_arm = 1'b1; tick(); I_arm = 1'b0;
    check("f_arm_clr_ovf", 32'(O_overflow), 32'(0));
    check("f_arm_clr_drop", 32'(O_drop_count), 32'(0));
    repeat (2) tick();
    check("f_wait_trig", 32'(O_state), 32'(ST_ARMED));
    I_trigger = 1'b1; I_event = 1'b1; tick(); I_trigger = 1'b0; I_event = 1'b0;
    check("f_capture", 32'(O_state), 32'(ST_CAPTURE));
    tick();
    check("f_trig_ev_wr", 32'(O_fifo_wr), 32'(0));
    check("f_trig_ev_ovf", 32'(O_overflow), 32'(0));
    repeat (259) tick();
    I_event = 1'b1; tick(); I_event = 1'b0;
    check_rec("f_time", FE_FIFO_CMD_TIME, 16'd260);
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    check("f_abort_idle", 32'(O_state), 32'(ST_IDLE));
    check("f_abort_wr", 32'(O_fifo_wr), 32'(0));
    tick();
    check("f_abort_wr2", 32'(O_fifo_wr), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_sched.md
TRACE_CAPTURE_SCHED -- requirements
Module: trace_capture_sched

Interface
REQ-001 SHALL have parameter pTIMESTAMP_FULL_WIDTH, default 16, full timestamp width.
REQ-002 SHALL have parameter pCOUNT_WIDTH, default 16, event-limit and drop-counter width.
REQ-003 SHALL have port trace_clk  in  1  clock.
REQ-004 SHALL have port reset  in  1  reset: synchronous, active-high.
REQ-005 SHALL have port I_arm  in  1  one-cycle arm pulse.
REQ-006 SHALL have port I_abort  in  1  force return to IDLE.
REQ-007 SHALL have port I_trigger_mode  in  1  0 = capture on arm, 1 = wait for trigger.
REQ-008 SHALL have port I_trigger  in  1  trigger pulse from pattern matcher.
REQ-009 SHALL have port I_max_events  in  pCOUNT_WIDTH  event-write limit; 0 = unlimited.
REQ-010 SHALL have port I_event  in  1  front-end event strobe.
REQ-011 SHALL have port I_data_cmd  in  2  command for the event (DATA or STAT).
REQ-012 SHALL have port I_max_short_timestamp  in  16  largest time encodable in a short record.
REQ-013 SHALL have port I_fifo_write_allowed  in  1  FIFO has room.
REQ-014 SHALL have port O_fifo_wr  out  1  registered FIFO write request.
REQ-015 SHALL have port O_fifo_command  out  2  registered command.
REQ-016 SHALL have port O_fifo_time  out  pTIMESTAMP_FULL_WIDTH  registered time field.
REQ-017 SHALL have port O_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-018 SHALL have port O_overflow  out  1  sticky: an event or record was lost.
REQ-019 SHALL have port O_drop_count  out  pCOUNT_WIDTH  saturating count of lost events.

Function
REQ-020 FSM transitions SHALL be: IDLE->ARMED on I_arm; ARMED->CAPTURE on next cycle (mode 0) or on I_trigger (mode 1); CAPTURE->DONE when the event-write count equals nonzero I_max_events; DONE->ARMED on I_arm; any state->IDLE on I_abort, which has priority.
REQ-021 Entry to ARMED SHALL clear the event-write count, O_overflow and O_drop_count.
REQ-022 Timestamp counter ts SHALL be 0 on the first CAPTURE cycle, increment each CAPTURE cycle, saturate at all-ones, and load 1 on every cycle a write is issued.
REQ-023 I_event outside CAPTURE, including the trigger cycle, SHALL be ignored and not counted as dropped.
REQ-024 Event in CAPTURE with ts <= I_max_short_timestamp SHALL produce, one cycle later, O_fifo_wr=1, O_fifo_command=I_data_cmd, O_fifo_time=ts.
REQ-025 Event with ts > I_max_short_timestamp SHALL produce a TIME record (O_fifo_time=ts) one cycle later, then the pending event record with O_fifo_time=1 on the following cycle.
REQ-026 An event arriving on the cycle its predecessor's pending record is issued SHALL be dropped, setting O_overflow.
REQ-027 With no event and ts all-ones, a TIME record with O_fifo_time=ts SHALL be issued.
REQ-028 Any record due while I_fifo_write_allowed=0 SHALL not be written; ts SHALL NOT reload, O_overflow SHALL set, and a lost event SHALL increment O_drop_count.
REQ-029 Only DATA/STAT writes SHALL increment the event-write count; the limit-reaching write SHALL be issued, and no write SHALL follow it.
REQ-030 O_fifo_wr SHALL be a single-cycle pulse per record; at most one record per cycle.

Reset
REQ-031 Reset SHALL force the following, and SHALL discard any pending record: O_state=IDLE, O_fifo_wr=0, O_fifo_command=0, O_fifo_time=0, O_overflow=0, O_drop_count=0, ts=0, event-write count=0.

Configuration
REQ-032 With TRACE_SCHED_DROP_COUNT_EN defined, O_drop_count SHALL count as specified; without it, O_drop_count SHALL be tied to 0 and its counter SHALL be absent, while O_overflow is unaffected.

Structure
REQ-033 FE_FIFO_CMD_DATA/TIME/STAT encodings and the FSM state encodings SHALL reside in the shared trace defines include.
REQ-034 The saturating timestamp counter SHALL be a sub-module named trace_sched_timestamp.

Verification
REQ-035 The bench SHALL cover: mode 0, I_arm, events at CAPTURE cycles 3 and 5, max_short=255 -> DATA records with time 3 then 2.
REQ-036 The bench SHALL cover: event at ts=300, max_short=255 -> TIME record time=300, next cycle event record time=1.
REQ-037 The bench SHALL cover: no events for 65535 cycles in CAPTURE -> one TIME record time=0xFFFF, ts reloads to 1.
REQ-038 The bench SHALL cover: I_max_events=2, three events -> two event writes, O_state=DONE, third event not written.
REQ-039 The bench SHALL cover: I_fifo_write_allowed=0 during one event -> no write, O_overflow=1, O_drop_count=1 (0 without macro).
REQ-040 The bench SHALL cover: mode 1, event coincident with I_trigger -> no write; I_abort mid-CAPTURE -> O_state=IDLE next cycle, pending record discarded.
